// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants, state/owner encodings and length decode for mem_arbiter.
package mem_arbiter_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam logic RST_ACTIVE = 1'b0;
    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;
    typedef enum logic {OWN_IF, OWN_MEM} owner_e;

    // Codes 10 and 11 both mean a full word.
    function automatic logic [2:0] nbytes(input logic [1:0] len);
        return len == LEN_BYTE ? 3'd1 : len == LEN_HALF ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IF/MEM requester ports, 8-bit RAM port and busy flag of the arbiter.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic [7:0]        ram_din;
    logic              busy;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        output if_data, if_done, mem_rdata, mem_done, ram_addr, ram_dout, ram_wr, busy
    );
    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        input  if_data, if_done, mem_rdata, mem_done, ram_addr, ram_dout, ram_wr, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF/MEM word/half/byte transactions onto an 8-bit synchronous RAM,
// MEM has fixed priority over IF.
module mem_arbiter import mem_arbiter_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    state_e            state_q;
    owner_e            owner_q;
    logic              we_q;
    logic [2:0]        n_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [31:0]       if_data_q;
    logic [31:0]       mem_rdata_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_dout_q;
    logic              ram_wr_q;
    logic              if_done_q;
    logic              mem_done_q;
    logic              busy_q;

    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [2:0]        cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        dout_d;
    logic [31:0]       asm_d;

    // In READ, cnt_q counts addresses already presented; ram_din belongs to byte cnt_q-1.
    always_comb begin
        grant_we   = bus.mem_req && bus.mem_we;
        grant_addr = bus.mem_req ? bus.mem_addr : bus.if_addr;
        cnt_d      = cnt_q + 3'd1;
        addr_d     = addr_q + ADDR_W'(cnt_d);
        dout_d     = wdata_q[{cnt_d[1:0], 3'b000} +: 8];
        asm_d      = asm_q;
        asm_d[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = bus.ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            n_q         <= 3'd0;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            ram_addr_q  <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.mem_req || bus.if_req) begin
                    owner_q    <= bus.mem_req ? OWN_MEM : OWN_IF;
                    we_q       <= grant_we;
                    n_q        <= bus.mem_req ? nbytes(bus.mem_len) : 3'd4;
                    cnt_q      <= 3'd0;
                    addr_q     <= grant_addr;
                    wdata_q    <= bus.mem_wdata;
                    asm_q      <= '0;
                    ram_addr_q <= grant_addr;
                    ram_dout_q <= grant_we ? bus.mem_wdata[7:0] : ram_dout_q;
                    ram_wr_q   <= grant_we;
                    busy_q     <= 1'b1;
                    state_q    <= grant_we ? S_WRITE : S_READ;
                end
                S_READ: begin
                    cnt_q <= cnt_d;
                    if (cnt_q != 3'd0) asm_q <= asm_d;
                    if (cnt_d < n_q) ram_addr_q <= addr_d;
                    if (cnt_q == n_q) begin
                        state_q     <= S_DONE;
                        if_done_q   <= owner_q == OWN_IF;
                        mem_done_q  <= owner_q == OWN_MEM;
                        if_data_q   <= owner_q == OWN_IF ? asm_d : if_data_q;
                        mem_rdata_q <= owner_q == OWN_MEM ? asm_d : mem_rdata_q;
                    end
                end
                S_WRITE: if (cnt_d < n_q) begin
                    cnt_q      <= cnt_d;
                    ram_addr_q <= addr_d;
                    ram_dout_q <= dout_d;
                end else begin
                    ram_wr_q   <= 1'b0;
                    state_q    <= S_DONE;
                    if_done_q  <= owner_q == OWN_IF;
                    mem_done_q <= owner_q == OWN_MEM;
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    if_done_q  <= 1'b0;
                    mem_done_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.if_data   = if_data_q;
    assign bus.if_done   = if_done_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_wr    = ram_wr_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus against a cycle-indexed transaction model plus a byte RAM.
module tb_mem_arbiter;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int free_c = 0;
    bit chk_on = 1'b0;

    bit          exp_busy [MAXC];
    bit          exp_wr [MAXC];
    bit          exp_av [MAXC];
    bit          exp_ifdn [MAXC];
    bit          exp_memdn [MAXC];
    bit          upd_if_v [MAXC];
    bit          upd_mem_v [MAXC];
    logic [31:0] exp_addr [MAXC];
    logic [7:0]  exp_dout [MAXC];
    logic [31:0] upd_if [MAXC];
    logic [31:0] upd_mem [MAXC];
    logic [31:0] m_ifd = 32'h0;
    logic [31:0] m_memd = 32'h0;

    logic [7:0] ram [logic [31:0]];
    logic [7:0] refm [logic [31:0]];
    logic [7:0] ram_q = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: data for the address presented in cycle c appears in cycle c+1.
    always @(posedge clk) begin
        if (bus.ram_wr === 1'b1) ram[bus.ram_addr] = bus.ram_dout;
        ram_q <= (!$isunknown(bus.ram_addr) && ram.exists(bus.ram_addr)) ? ram[bus.ram_addr] : 8'h00;
    end
    assign bus.ram_din = ram_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] rref(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rram(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic int nlen(input logic [1:0] len);
        return len == 2'b00 ? 1 : len == 2'b01 ? 2 : 4;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a] = d;
        refm[a] = d;
    endtask

    // Transaction sampled at end of cycle s: bytes in s+1..s+n, done n+1 (write) or n+2 (read) after s.
    task automatic sched(input bit own_mem, input bit we, input int n, input logic [31:0] a,
                         input logic [31:0] wd, input int s, output int dn);
        logic [31:0] v = 32'h0;
        for (int t = 0; t < n; t++) begin
            exp_av[s+1+t] = 1'b1;
            exp_addr[s+1+t] = a + 32'(t);
            if (we) begin
                exp_wr[s+1+t] = 1'b1;
                exp_dout[s+1+t] = wd[8*t +: 8];
            end else v |= 32'(rref(a + 32'(t))) << (8 * t);
        end
        dn = we ? s + n + 1 : s + n + 2;
        for (int c = s + 1; c <= dn; c++) exp_busy[c] = 1'b1;
        if (own_mem) exp_memdn[dn] = 1'b1;
        else exp_ifdn[dn] = 1'b1;
        if (!we && own_mem) begin upd_mem_v[dn] = 1'b1; upd_mem[dn] = v; end
        if (!we && !own_mem) begin upd_if_v[dn] = 1'b1; upd_if[dn] = v; end
        free_c = dn + 1;
    endtask

    task automatic model_reset(input int k);
        for (int c = k + 1; c < MAXC; c++) begin
            exp_busy[c] = 0; exp_wr[c] = 0; exp_av[c] = 0; exp_ifdn[c] = 0;
            exp_memdn[c] = 0; upd_if_v[c] = 0; upd_mem_v[c] = 0;
        end
        upd_if_v[k+1] = 1'b1; upd_if[k+1] = 32'h0;
        upd_mem_v[k+1] = 1'b1; upd_mem[k+1] = 32'h0;
        free_c = k + 1;
    endtask

    always @(negedge clk) begin
        if (chk_on && cyc < MAXC) begin
            if (upd_if_v[cyc]) m_ifd = upd_if[cyc];
            if (upd_mem_v[cyc]) m_memd = upd_mem[cyc];
            if (exp_wr[cyc]) refm[exp_addr[cyc]] = exp_dout[cyc];
            chk("busy", 32'(bus.busy), 32'(exp_busy[cyc]));
            chk("ram_wr", 32'(bus.ram_wr), 32'(exp_wr[cyc]));
            chk("if_done", 32'(bus.if_done), 32'(exp_ifdn[cyc]));
            chk("mem_done", 32'(bus.mem_done), 32'(exp_memdn[cyc]));
            chk("if_data", bus.if_data, m_ifd);
            chk("mem_rdata", bus.mem_rdata, m_memd);
            if (exp_av[cyc]) chk("ram_addr", bus.ram_addr, exp_addr[cyc]);
            if (exp_wr[cyc]) chk("ram_dout", 32'(bus.ram_dout), 32'(exp_dout[cyc]));
        end
    end

    task automatic mem_txn(input bit we, input logic [1:0] len, input logic [31:0] a,
                           input logic [31:0] wd, output int s, output int dn);
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_len = len;
        bus.mem_addr = a; bus.mem_wdata = wd;
        s = cyc > free_c ? cyc : free_c;
        sched(1'b1, we, nlen(len), a, wd, s, dn);
        while (cyc < dn) @(negedge clk);
        bus.mem_req = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] a, output int s, output int dn);
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = a;
        s = cyc > free_c ? cyc : free_c;
        sched(1'b0, 1'b0, 4, a, 32'h0, s, dn);
        while (cyc < dn) @(negedge clk);
        bus.if_req = 1'b0;
    endtask

    initial begin
        int s, dn, sm, dm, si, di;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'b00;
        bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        poke(32'h10, 8'hAA); poke(32'h11, 8'h55);
        poke(32'h300, 8'h11); poke(32'h301, 8'h22); poke(32'h302, 8'h33); poke(32'h303, 8'h44);

        // Reset held through the edges ending cycles 0..2 with if_req high.
        @(posedge clk);
        #1 chk_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ram_addr", bus.ram_addr, 32'h0);
        chk("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
        rst = 1'b1;
        bus.if_req = 1'b0;

        if_txn(32'h100, s, dn);
        chk("if_latency", 32'(dn - s), 32'd6);
        chk("if_done_lit", 32'(bus.if_done), 32'h1);
        chk("if_data_lit", bus.if_data, 32'h0000_0513);

        mem_txn(1'b1, 2'b10, 32'h200, 32'hDEAD_BEEF, s, dn);
        chk("wr_latency", 32'(dn - s), 32'd5);
        chk("wr_done_lit", 32'(bus.mem_done), 32'h1);
        mem_txn(1'b0, 2'b00, 32'h201, 32'h0, s, dn);
        chk("rb_latency", 32'(dn - s), 32'd3);
        chk("rb_data_lit", bus.mem_rdata, 32'h0000_00BE);

        // Simultaneous requests: MEM halfword read first, IF word read right after.
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'b01; bus.mem_addr = 32'h10;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        sm = cyc > free_c ? cyc : free_c;
        sched(1'b1, 1'b0, 2, 32'h10, 32'h0, sm, dm);
        si = free_c;
        sched(1'b0, 1'b0, 4, 32'h100, 32'h0, si, di);
        while (cyc < dm) @(negedge clk);
        bus.mem_req = 1'b0;
        chk("both_mem_data_lit", bus.mem_rdata, 32'h0000_55AA);
        chk("both_if_pending", 32'(bus.if_done), 32'h0);
        while (cyc < di) @(negedge clk);
        bus.if_req = 1'b0;
        chk("both_if_data_lit", bus.if_data, 32'h0000_0513);

        mem_txn(1'b1, 2'b11, 32'hFFFF_FFFE, 32'h1234_5678, s, dn);

        // Reset lands on the edge that writes byte 1 of a word write.
        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'b10;
        bus.mem_addr = 32'h300; bus.mem_wdata = 32'hCAFE_F00D;
        s = cyc > free_c ? cyc : free_c;
        sched(1'b1, 1'b1, 4, 32'h300, 32'hCAFE_F00D, s, dn);
        while (cyc < s + 2) @(negedge clk);
        rst = 1'b0;
        bus.mem_req = 1'b0;
        model_reset(s + 2);
        @(negedge clk);
        rst = 1'b1;
        mem_txn(1'b0, 2'b01, 32'h301, 32'h0, s, dn);
        chk("post_rst_read_lit", bus.mem_rdata, 32'h0000_33F0);

        repeat (3) @(negedge clk);
        foreach (refm[k]) chk("ram_vs_model", 32'(rram(k)), 32'(refm[k]));
        chk("ram_200", 32'(rram(32'h200)), 32'hEF);
        chk("ram_201", 32'(rram(32'h201)), 32'hBE);
        chk("ram_202", 32'(rram(32'h202)), 32'hAD);
        chk("ram_203", 32'(rram(32'h203)), 32'hDE);
        chk("ram_fffffffe", 32'(rram(32'hFFFF_FFFE)), 32'h78);
        chk("ram_ffffffff", 32'(rram(32'hFFFF_FFFF)), 32'h56);
        chk("ram_0", 32'(rram(32'h0)), 32'h34);
        chk("ram_1", 32'(rram(32'h1)), 32'h12);
        chk("ram_300", 32'(rram(32'h300)), 32'h0D);
        chk("ram_301", 32'(rram(32'h301)), 32'hF0);
        chk("ram_302", 32'(rram(32'h302)), 32'h33);
        chk("ram_303", 32'(rram(32'h303)), 32'h44);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
